cpu_mult_unit: RTL

Parametrised, pipelined integer multiplier for the CPU's execute stage. It supersedes the fixed 32-bit, low-half-only multiply cell. The unit adds signed/unsigned operand modes, high-half result selection, configurable width and pipeline depth, and a valid/ready handshake with back-pressure and flush. It accepts one operation per cycle and returns results in order, each carrying an opaque tag.

---
 rtl/cpu_mult_unit_if.sv | 27 ++
 rtl/cpu_mult_unit.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_mult_unit_if.sv
// Request/response bundle between the execute stage and the pipelined multiplier.
// The master side issues operations and consumes results.
interface cpu_mult_unit_if #(
   parameter int DATA_W = 32,
   parameter int TAG_W  = 5
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] A_mul_src1;
   logic [DATA_W-1:0] A_mul_src2;
   logic [1:0]        mode;
   logic [TAG_W-1:0]  in_tag;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] A_mul_result;
   logic [TAG_W-1:0]  out_tag;

   modport master (
      output in_valid, A_mul_src1, A_mul_src2, mode, in_tag, out_ready,
      input  in_ready, out_valid, A_mul_result, out_tag
   );

   modport slave (
      input  in_valid, A_mul_src1, A_mul_src2, mode, in_tag, out_ready,
      output in_ready, out_valid, A_mul_result, out_tag
   );
endinterface

// File: rtl/cpu_mult_unit.sv
// Pipelined limb-decomposed multiplier with MUL/MULH/MULHSU/MULHU selection,
// tagged in-order results and valid/ready back-pressure with flush.
module cpu_mult_unit #(
   parameter int DATA_W      = 32,
   parameter int LIMB_W      = 16,
   parameter int PIPE_STAGES = 2,
   parameter int TAG_W       = 5
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           flush,
   cpu_mult_unit_if.slave bus
);
   localparam int NL  = DATA_W / LIMB_W;
   localparam int NPP = NL * NL;
   localparam int PPW = 2 * LIMB_W;
   localparam int PW  = 2 * DATA_W;

   localparam logic [1:0] MODE_MUL    = 2'b00;
   localparam logic [1:0] MODE_MULH   = 2'b01;
   localparam logic [1:0] MODE_MULHSU = 2'b10;

   typedef logic [NPP-1:0][PPW-1:0] pp_t;
   typedef logic [NL-1:0][PW-1:0]   rows_t;

   function automatic pp_t limb_products(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
      pp_t pp;
      for (int i = 0; i < NL; i++) begin
         for (int j = 0; j < NL; j++) begin
            pp[i*NL+j] = {{LIMB_W{1'b0}}, a[i*LIMB_W +: LIMB_W]} *
                         {{LIMB_W{1'b0}}, b[j*LIMB_W +: LIMB_W]};
         end
      end
      return pp;
   endfunction

   // A signed operand equals its unsigned pattern minus 2^DATA_W when negative, so
   // the product needs (sa*B + sb*A) subtracted at weight 2^DATA_W; the sa*sb term wraps out.
   function automatic logic [DATA_W-1:0] sign_correction(input logic [1:0] mode,
                                                         input logic [DATA_W-1:0] a,
                                                         input logic [DATA_W-1:0] b);
      logic sa;
      logic sb;
      sa = ((mode == MODE_MULH) || (mode == MODE_MULHSU)) && a[DATA_W-1];
      sb = (mode == MODE_MULH) && b[DATA_W-1];
      return (sa ? b : '0) + (sb ? a : '0);
   endfunction

   function automatic rows_t row_sums(input pp_t pp);
      rows_t rows;
      for (int i = 0; i < NL; i++) begin
         rows[i] = '0;
         for (int j = 0; j < NL; j++) begin
            rows[i] = rows[i] + (PW'(pp[i*NL+j]) << (j*LIMB_W));
         end
      end
      return rows;
   endfunction

   function automatic logic [PW-1:0] sum_rows(input rows_t rows, input logic [DATA_W-1:0] corr);
      logic [PW-1:0] acc;
      acc = '0;
      for (int i = 0; i < NL; i++) begin
         acc = acc + (rows[i] << (i*LIMB_W));
      end
      return acc - {corr, {DATA_W{1'b0}}};
   endfunction

   function automatic logic [DATA_W-1:0] select_half(input logic [1:0] mode, input logic [PW-1:0] prod);
      return (mode == MODE_MUL) ? prod[DATA_W-1:0] : prod[PW-1:DATA_W];
   endfunction

   logic [PIPE_STAGES:1] vld_q;
   logic [PIPE_STAGES:1] vld_d;
   logic [PIPE_STAGES:1] adv;
   logic [TAG_W-1:0]     tag_q [1:PIPE_STAGES];
   logic [TAG_W-1:0]     tag_d [1:PIPE_STAGES];
   logic [DATA_W-1:0]    result;

   // A stage may load when it is empty or its occupant moves on this cycle.
   always_comb begin
      adv = '0;
      adv[PIPE_STAGES] = !vld_q[PIPE_STAGES] || bus.out_ready;
      for (int k = PIPE_STAGES - 1; k >= 1; k--) begin
         adv[k] = !vld_q[k] || adv[k+1];
      end
   end

   always_comb begin
      vld_d = vld_q;
      if (adv[1]) vld_d[1] = bus.in_valid;
      for (int k = 2; k <= PIPE_STAGES; k++) begin
         if (adv[k]) vld_d[k] = vld_q[k-1];
      end
      if (flush) vld_d = '0;
   end

   always_ff @(posedge clk) begin
      if (reset) vld_q <= '0;
      else       vld_q <= vld_d;
   end

   always_comb begin
      tag_d = tag_q;
      if (adv[1]) tag_d[1] = bus.in_tag;
      for (int k = 2; k <= PIPE_STAGES; k++) begin
         if (adv[k]) tag_d[k] = tag_q[k-1];
      end
   end

   always_ff @(posedge clk) tag_q <= tag_d;

   // ---- stage 1: limb partial products and sign correction ----
   pp_t               pp_p1_q, pp_p1_d;
   logic [DATA_W-1:0] corr_p1_q, corr_p1_d;
   logic [1:0]        mode_p1_q, mode_p1_d;

   always_comb begin
      pp_p1_d   = pp_p1_q;
      corr_p1_d = corr_p1_q;
      mode_p1_d = mode_p1_q;
      if (adv[1]) begin
         pp_p1_d   = limb_products(bus.A_mul_src1, bus.A_mul_src2);
         corr_p1_d = sign_correction(bus.mode, bus.A_mul_src1, bus.A_mul_src2);
         mode_p1_d = bus.mode;
      end
   end

   always_ff @(posedge clk) begin
      pp_p1_q   <= pp_p1_d;
      corr_p1_q <= corr_p1_d;
      mode_p1_q <= mode_p1_d;
   end

   generate
      if (PIPE_STAGES == 2) begin : g_short
         // ---- stage 2: full reduction and half select ----
         logic [DATA_W-1:0] res_p2_q, res_p2_d;

         always_comb begin
            res_p2_d = res_p2_q;
            if (adv[2]) res_p2_d = select_half(mode_p1_q, sum_rows(row_sums(pp_p1_q), corr_p1_q));
         end

         always_ff @(posedge clk) res_p2_q <= res_p2_d;

         assign result = res_p2_q;
      end else begin : g_deep
         // ---- stage 2: per-row sums; stage 3: final sum; stage 4: output retime ----
         rows_t             rows_p2_q, rows_p2_d;
         logic [DATA_W-1:0] corr_p2_q, corr_p2_d;
         logic [1:0]        mode_p2_q, mode_p2_d;
         logic [DATA_W-1:0] res_q [3:PIPE_STAGES];
         logic [DATA_W-1:0] res_d [3:PIPE_STAGES];

         always_comb begin
            rows_p2_d = rows_p2_q;
            corr_p2_d = corr_p2_q;
            mode_p2_d = mode_p2_q;
            if (adv[2]) begin
               rows_p2_d = row_sums(pp_p1_q);
               corr_p2_d = corr_p1_q;
               mode_p2_d = mode_p1_q;
            end
            res_d = res_q;
            if (adv[3]) res_d[3] = select_half(mode_p2_q, sum_rows(rows_p2_q, corr_p2_q));
            for (int k = 4; k <= PIPE_STAGES; k++) begin
               if (adv[k]) res_d[k] = res_q[k-1];
            end
         end

         always_ff @(posedge clk) begin
            rows_p2_q <= rows_p2_d;
            corr_p2_q <= corr_p2_d;
            mode_p2_q <= mode_p2_d;
            res_q     <= res_d;
         end

         assign result = res_q[PIPE_STAGES];
      end
   endgenerate

   assign bus.in_ready     = adv[1];
   assign bus.out_valid    = vld_q[PIPE_STAGES];
   assign bus.A_mul_result = result;
   assign bus.out_tag      = tag_q[PIPE_STAGES];
endmodule
